// File: rtl/mux_stream_pkg.sv
// Shared constants and helpers for the N-to-1 streaming multiplexer.
package mux_stream_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_nt1_stream_rr_pick.sv
// Rotating-priority encoder: first set req bit at or after base, wrapping mod N.
module rr_pick #(
   parameter int N     = 16,
   parameter int SEL_W = 4
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] base,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   logic [2*N-1:0]   dbl;
   logic [N-1:0]     rot;
   logic [SEL_W-1:0] off;
   logic [SEL_W:0]   sum;

   // rot[0] is req[base]; doubling the vector makes the wrap free
   assign dbl = {req, req};
   assign rot = N'(dbl >> base);

   always_comb begin
      gnt_any = 1'b0;
      off     = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (rot[i]) begin
            gnt_any = 1'b1;
            off     = SEL_W'(i);
         end
      end
   end

   assign sum     = {1'b0, base} + {1'b0, off};
   assign gnt_idx = (sum >= (SEL_W+1)'(N)) ? SEL_W'(sum - (SEL_W+1)'(N)) : sum[SEL_W-1:0];

endmodule

// File: rtl/mux_nt1_stream.sv
// N-to-1 valid/ready multiplexer with fixed or round-robin selection and a
// single registered output stage.
module mux_nt1_stream
   import mux_stream_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 16,
   parameter int SEL_W = 4,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   out_sel,
   output logic [CNT_W-1:0]   xfer_cnt
);

   if (SEL_W != clog2(N)) begin : g_sel_w_chk
      $error("mux_nt1_stream: SEL_W must equal clog2(N)");
   end

   logic             load_en;
   logic             sel_ok;
   logic             chosen_any;
   logic             xfer;
   logic [SEL_W-1:0] chosen;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_idx;
   logic             rr_any;
   logic [SEL_W-1:0] rr_next;
   logic [SEL_W:0]   chosen_p1;
   logic [WIDTH-1:0] chosen_data;

   rr_pick #(.N(N), .SEL_W(SEL_W)) u_rr_pick (
      .req     (in_valid),
      .base    (rr_ptr),
      .gnt_idx (rr_idx),
      .gnt_any (rr_any)
   );

   // when N fills the select space every sel value is a real channel
   if (N == (1 << SEL_W)) begin : g_sel_full
      assign sel_ok = 1'b1;
   end else begin : g_sel_part
      assign sel_ok = (sel < SEL_W'(N));
   end

   always_comb begin
      chosen     = sel;
      chosen_any = sel_ok;
      if (mode == MODE_RR) begin
         chosen     = rr_idx;
         chosen_any = rr_any;
      end
   end

   assign load_en = !out_valid | out_ready;

   always_comb begin
      in_ready    = '0;
      chosen_data = '0;
      xfer        = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (chosen_any && (chosen == SEL_W'(k))) begin
            in_ready[k] = load_en;
            chosen_data = in_data[k*WIDTH +: WIDTH];
            xfer        = load_en & in_valid[k];
         end
      end
   end

   assign chosen_p1 = {1'b0, chosen} + (SEL_W+1)'(1);
   assign rr_next   = (chosen_p1 == (SEL_W+1)'(N)) ? '0 : chosen_p1[SEL_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         xfer_cnt  <= '0;
         rr_ptr    <= '0;
      end else begin
         if (xfer) begin
            out_data  <= chosen_data;
            out_sel   <= chosen;
            out_valid <= 1'b1;
            xfer_cnt  <= xfer_cnt + CNT_W'(1);
            // fixed-mode traffic leaves the rotation point alone
            if (mode == MODE_RR) rr_ptr <= rr_next;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_nt1_stream.sv
// Scoreboard bench for mux_nt1_stream: a 16-channel instance, a 12-channel
// instance and a 4-bit-counter instance sharing one clock and reset.
module tb_mux_nt1_stream;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [16*W-1:0] a_data;
   logic [15:0]     a_valid, a_ready;
   logic            a_mode, a_ovalid, a_oready;
   logic [3:0]      a_sel, a_osel;
   logic [W-1:0]    a_odata;
   logic [31:0]     a_cnt;

   logic [12*W-1:0] b_data;
   logic [11:0]     b_valid, b_ready;
   logic            b_mode, b_ovalid, b_oready;
   logic [3:0]      b_sel, b_osel;
   logic [W-1:0]    b_odata;
   logic [31:0]     b_cnt;

   logic [16*8-1:0] c_data;
   logic [15:0]     c_valid, c_ready;
   logic            c_mode, c_ovalid, c_oready;
   logic [3:0]      c_sel, c_osel;
   logic [7:0]      c_odata;
   logic [3:0]      c_cnt;

   mux_nt1_stream #(.WIDTH(W), .N(16), .SEL_W(4), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
      .mode(a_mode), .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid),
      .out_ready(a_oready), .out_sel(a_osel), .xfer_cnt(a_cnt));

   mux_nt1_stream #(.WIDTH(W), .N(12), .SEL_W(4), .CNT_W(32)) dut_b (
      .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
      .mode(b_mode), .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid),
      .out_ready(b_oready), .out_sel(b_osel), .xfer_cnt(b_cnt));

   mux_nt1_stream #(.WIDTH(8), .N(16), .SEL_W(4), .CNT_W(4)) dut_c (
      .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
      .mode(c_mode), .sel(c_sel), .out_data(c_odata), .out_valid(c_ovalid),
      .out_ready(c_oready), .out_sel(c_osel), .xfer_cnt(c_cnt));

   typedef struct {
      logic [3:0]   sel;
      logic [W-1:0] data;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   errors  = 0;

   task automatic test_reset();
      #1;
      vectors++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", a_ovalid); end
      vectors++; if (a_odata !== '0) begin errors++; $display("FAIL rst_data got %0h want 0", a_odata); end
      vectors++; if (a_osel !== 4'd0) begin errors++; $display("FAIL rst_sel got %0h want 0", a_osel); end
      vectors++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0h want 0", a_cnt); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_fixed_sweep();
      int   sels[8] = '{0, 1, 4, 5, 9, 12, 13, 14};
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a_mode = 1'b0; a_oready = 1'b1; a_valid = 16'hFFFF; a_sel = 4'(sels[i]);
         sbq.push_back('{sel: 4'(sels[i]), data: W'(sels[i])});
         #1;
         vectors++; if (a_ready !== (16'd1 << sels[i])) begin errors++; $display("FAIL sweep_ready got %0h want %0h", a_ready, 16'd1 << sels[i]); end
         @(posedge clk); #1;
         if (sbq.size() == 0) begin errors++; $display("FAIL sweep_sb empty queue"); end
         else begin
            e = sbq.pop_front();
            vectors++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL sweep_valid got %0h want 1", a_ovalid); end
            vectors++; if (a_odata !== e.data) begin errors++; $display("FAIL sweep_data got %0h want %0h", a_odata, e.data); end
            vectors++; if (a_osel !== e.sel) begin errors++; $display("FAIL sweep_sel got %0h want %0h", a_osel, e.sel); end
         end
      end
      vectors++; if (a_cnt !== 32'd8) begin errors++; $display("FAIL sweep_cnt got %0d want 8", a_cnt); end
      @(negedge clk) a_valid = '0;
      @(posedge clk); #1;
      vectors++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0h want 0", a_ovalid); end
      vectors++; if (a_odata !== W'(14)) begin errors++; $display("FAIL idle_hold got %0h want e", a_odata); end
   endtask

   task automatic test_backpressure();
      exp_t e;
      @(negedge clk);
      a_sel = 4'd3; a_valid = 16'h0008; a_oready = 1'b0;
      #1;
      vectors++; if (a_ready !== 16'h0008) begin errors++; $display("FAIL bp_ready0 got %0h want 8", a_ready); end
      @(posedge clk); #1;
      vectors++; if (a_odata !== W'(3)) begin errors++; $display("FAIL bp_first got %0h want 3", a_odata); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk) a_data[3*W +: W] = 32'hDEAD0000 + W'(i);
         #1;
         vectors++; if (a_ready !== 16'h0) begin errors++; $display("FAIL bp_ready got %0h want 0", a_ready); end
         @(posedge clk); #1;
         vectors++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0h want 1", a_ovalid); end
         vectors++; if (a_odata !== W'(3)) begin errors++; $display("FAIL bp_hold got %0h want 3", a_odata); end
         vectors++; if (a_cnt !== 32'd9) begin errors++; $display("FAIL bp_cnt got %0d want 9", a_cnt); end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_oready = 1'b1; a_data[3*W +: W] = W'(100 + i);
         sbq.push_back('{sel: 4'd3, data: W'(100 + i)});
         @(posedge clk); #1;
         if (sbq.size() == 0) begin errors++; $display("FAIL bp_sb empty queue"); end
         else begin
            e = sbq.pop_front();
            vectors++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL resume_valid got %0h want 1", a_ovalid); end
            vectors++; if (a_odata !== e.data) begin errors++; $display("FAIL resume_data got %0h want %0h", a_odata, e.data); end
            vectors++; if (a_cnt !== 32'(10 + i)) begin errors++; $display("FAIL resume_cnt got %0d want %0d", a_cnt, 10 + i); end
         end
      end
      @(negedge clk);
      a_valid = '0; a_data[3*W +: W] = W'(3);
   endtask

   task automatic test_round_robin();
      int   seq[6] = '{0, 5, 10, 15, 0, 5};
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a_mode = 1'b1; a_valid = 16'h8421; a_oready = 1'b1;
         sbq.push_back('{sel: 4'(seq[i]), data: W'(seq[i])});
         #1;
         vectors++; if (a_ready !== (16'd1 << seq[i])) begin errors++; $display("FAIL rr_ready got %0h want %0h", a_ready, 16'd1 << seq[i]); end
         @(posedge clk); #1;
         if (sbq.size() == 0) begin errors++; $display("FAIL rr_sb empty queue"); end
         else begin
            e = sbq.pop_front();
            vectors++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL rr_valid got %0h want 1", a_ovalid); end
            vectors++; if (a_osel !== e.sel) begin errors++; $display("FAIL rr_sel got %0d want %0d", a_osel, e.sel); end
            vectors++; if (a_odata !== e.data) begin errors++; $display("FAIL rr_data got %0h want %0h", a_odata, e.data); end
         end
      end
      @(negedge clk);
      a_valid = '0; a_mode = 1'b0;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      b_mode = 1'b0; b_oready = 1'b1; b_sel = 4'd5; b_valid = 12'hFFF;
      @(posedge clk); #1;
      vectors++; if (b_odata !== 32'h105) begin errors++; $display("FAIL n12_first got %0h want 105", b_odata); end
      @(negedge clk) b_sel = 4'd13;
      #1;
      vectors++; if (b_ready !== 12'h0) begin errors++; $display("FAIL n12_sel13_ready got %0h want 0", b_ready); end
      @(posedge clk); #1;
      vectors++; if (b_ovalid !== 1'b0) begin errors++; $display("FAIL n12_drop got %0h want 0", b_ovalid); end
      vectors++; if (b_odata !== 32'h105) begin errors++; $display("FAIL n12_hold got %0h want 105", b_odata); end
      vectors++; if (b_cnt !== 32'd1) begin errors++; $display("FAIL n12_cnt got %0d want 1", b_cnt); end
      @(negedge clk) b_sel = 4'd12;
      #1;
      vectors++; if (b_ready !== 12'h0) begin errors++; $display("FAIL n12_sel12_ready got %0h want 0", b_ready); end
      b_mode = 1'b1; b_valid = 12'h800;
      #1;
      vectors++; if (b_ready !== 12'h800) begin errors++; $display("FAIL n12_rr_ready got %0h want 800", b_ready); end
      @(posedge clk); #1;
      vectors++; if (b_osel !== 4'd11) begin errors++; $display("FAIL n12_rr_sel got %0d want 11", b_osel); end
      vectors++; if (b_odata !== 32'h10B) begin errors++; $display("FAIL n12_rr_data got %0h want 10b", b_odata); end
      @(negedge clk) b_valid = 12'hFFF;
      #1;
      vectors++; if (b_ready !== 12'h001) begin errors++; $display("FAIL n12_wrap_ready got %0h want 1", b_ready); end
      @(posedge clk); #1;
      vectors++; if (b_osel !== 4'd0) begin errors++; $display("FAIL n12_wrap_sel got %0d want 0", b_osel); end
      vectors++; if (b_cnt !== 32'd3) begin errors++; $display("FAIL n12_wrap_cnt got %0d want 3", b_cnt); end
      @(negedge clk) b_valid = '0;
   endtask

   task automatic test_cnt_wrap();
      @(negedge clk);
      c_mode = 1'b0; c_sel = 4'd0; c_oready = 1'b1; c_valid = 16'h0001;
      repeat (15) @(posedge clk);
      #1;
      vectors++; if (c_cnt !== 4'd15) begin errors++; $display("FAIL cnt15 got %0d want 15", c_cnt); end
      @(posedge clk); #1;
      vectors++; if (c_cnt !== 4'd0) begin errors++; $display("FAIL cnt16 got %0d want 0", c_cnt); end
      @(posedge clk); #1;
      vectors++; if (c_cnt !== 4'd1) begin errors++; $display("FAIL cnt17 got %0d want 1", c_cnt); end
      vectors++; if (c_odata !== 8'h5A) begin errors++; $display("FAIL cnt_data got %0h want 5a", c_odata); end
      @(negedge clk) c_valid = '0;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      @(negedge clk);
      a_mode = 1'b0; a_sel = 4'd2; a_valid = 16'h0004; a_oready = 1'b0;
      @(posedge clk); #1;
      vectors++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0h want 1", a_ovalid); end
      #2 rst = 1'b1;
      #1;
      vectors++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0h want 0", a_ovalid); end
      vectors++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", a_cnt); end
      vectors++; if (a_odata !== '0) begin errors++; $display("FAIL mid_data got %0h want 0", a_odata); end
      @(negedge clk);
      rst = 1'b0; a_mode = 1'b1; a_valid = 16'h0408; a_oready = 1'b1;
      sbq.push_back('{sel: 4'd3, data: W'(3)});
      #1;
      vectors++; if (a_ready !== 16'h0008) begin errors++; $display("FAIL mid_rr_ready got %0h want 8", a_ready); end
      @(posedge clk); #1;
      if (sbq.size() == 0) begin errors++; $display("FAIL mid_sb empty queue"); end
      else begin
         e = sbq.pop_front();
         vectors++; if (a_osel !== e.sel) begin errors++; $display("FAIL mid_rr_sel got %0d want %0d", a_osel, e.sel); end
         vectors++; if (a_odata !== e.data) begin errors++; $display("FAIL mid_rr_data got %0h want %0h", a_odata, e.data); end
         vectors++; if (a_cnt !== 32'd1) begin errors++; $display("FAIL mid_rr_cnt got %0d want 1", a_cnt); end
      end
      @(negedge clk) a_valid = '0;
   endtask

   initial begin
      for (int k = 0; k < 16; k++) a_data[k*W +: W] = W'(k);
      for (int k = 0; k < 12; k++) b_data[k*W +: W] = W'(32'h100 + k);
      c_data = '0;
      c_data[7:0] = 8'h5A;
      a_valid = '0; a_mode = 1'b0; a_sel = '0; a_oready = 1'b1;
      b_valid = '0; b_mode = 1'b0; b_sel = '0; b_oready = 1'b1;
      c_valid = '0; c_mode = 1'b0; c_sel = '0; c_oready = 1'b1;
      test_reset();
      test_fixed_sweep();
      test_backpressure();
      test_round_robin();
      test_wrap();
      test_cnt_wrap();
      test_reset_mid();
      if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sbq.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
